// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial ALU and its slice.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } alu_state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: control[2]=0 is add/sub (control[0] inverts B),
// control[2]=1 selects AND/OR/NOR/XOR by control[1:0]. Carry chain always runs.
module serial_alu_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] control_i,
    output logic       res_o,
    output logic       cout_o
);

    logic b_eff;

    always_comb begin
        b_eff  = b_i ^ control_i[0];
        cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);
        res_o  = a_i ^ b_eff ^ cin_i;
        if (control_i[2]) begin
            unique case (control_i)
                ALU_AND: res_o = a_i & b_i;
                ALU_OR:  res_o = a_i | b_i;
                ALU_NOR: res_o = ~(a_i | b_i);
                default: res_o = a_i ^ b_i;
            endcase
        end
    end

endmodule

// File: rtl/serial_alu32.sv
// Bit-serial ALU sequencer, LSB first. Define SERIAL_ALU_DUAL_SLICE_EN to chain two
// slices per cycle (two bits per RUN edge, WIDTH must be even).
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one (or two) bits per edge through the slice, carry fed back
// DONE  | result and flags valid, done pulse for one cycle
module serial_alu32
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

`ifdef SERIAL_ALU_DUAL_SLICE_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int STEPS = WIDTH / LANES;
    localparam int CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2) begin : g_width_min
        $error("serial_alu32: WIDTH must be >= 2");
    end
`ifdef SERIAL_ALU_DUAL_SLICE_EN
    if (WIDTH % 2 != 0) begin : g_width_even
        $error("serial_alu32: WIDTH must be even with the dual-slice build");
    end
`endif

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, out_q;
    logic [2:0]       ctrl_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, carryout_q, overflow_q;

    logic             r0, c0;
    logic [LANES-1:0] lane_bits;
    logic             cin_msb, cout_msb;
    logic [WIDTH+LANES-1:0] res_cat;
    logic [WIDTH-1:0] res_next;

    serial_alu_slice u_slice0 (
        .a_i       (a_q[0]),
        .b_i       (b_q[0]),
        .cin_i     (carry_q),
        .control_i (ctrl_q),
        .res_o     (r0),
        .cout_o    (c0)
    );

`ifdef SERIAL_ALU_DUAL_SLICE_EN
    logic r1, c1;

    serial_alu_slice u_slice1 (
        .a_i       (a_q[1]),
        .b_i       (b_q[1]),
        .cin_i     (c0),
        .control_i (ctrl_q),
        .res_o     (r1),
        .cout_o    (c1)
    );

    assign lane_bits = {r1, r0};
    assign cin_msb   = c0;
    assign cout_msb  = c1;
`else
    assign lane_bits = r0;
    assign cin_msb   = carry_q;
    assign cout_msb  = c0;
`endif

    // New bits enter at the MSB end so after STEPS shifts bit 0 sits at out[0].
    assign res_cat  = {lane_bits, res_q};
    assign res_next = res_cat[WIDTH+LANES-1:LANES];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            out_q      <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        ctrl_q  <= control;
                        cnt_q   <= '0;
                        carry_q <= control[0] & ~control[2];
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> LANES;
                    b_q     <= b_q >> LANES;
                    res_q   <= res_next;
                    carry_q <= cout_msb;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        out_q      <= res_next;
                        carryout_q <= cout_msb & ~ctrl_q[2];
                        overflow_q <= (cin_msb ^ cout_msb) & ~ctrl_q[2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign out      = out_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = (out_q == '0);
    assign negative = out_q[WIDTH-1];

endmodule

// File: tb/tb_serial_alu32.sv
// Directed bench for serial_alu32: expected results are queued at start and
// compared when done pulses; latency and reset/abort behaviour are checked too.
module tb_serial_alu32;

    localparam int WIDTH = 32;
`ifdef SERIAL_ALU_DUAL_SLICE_EN
    localparam int LAT = WIDTH / 2 + 1;
`else
    localparam int LAT = WIDTH + 1;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  control = '0;
    logic        busy, done, carryout, overflow, zero, negative;
    logic [31:0] out;

    int   vectors = 0;
    int   miscompares = 0;
    int   edge_cnt = 0;
    exp_t sb_q[$];

    serial_alu32 #(.WIDTH(WIDTH)) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .control  (control),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        exp_t        e;
        logic [32:0] s;
        logic [31:0] bb;
        e = '0;
        if (!c[2]) begin
            bb    = c[0] ? ~b : b;
            s     = {1'b0, a} + {1'b0, bb} + {32'd0, c[0]};
            e.res = s[31:0];
            e.co  = s[32];
            e.ov  = (a[31] == bb[31]) && (e.res[31] != a[31]);
        end else begin
            case (c[1:0])
                2'd0:    e.res = a & b;
                2'd1:    e.res = a | b;
                2'd2:    e.res = ~(a | b);
                default: e.res = a ^ b;
            endcase
        end
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge, then scramble inputs to prove they were latched.
    task automatic issue(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        A = a; B = b; control = c; start = 1'b1;
        sb_q.push_back(model(a, b, c));
        @(posedge clk); #1;
        edge_cnt = 1;
        start = 1'b0;
        A = $urandom; B = $urandom; control = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(string tag);
        exp_t e;
        while (!done && edge_cnt < 200) begin
            @(posedge clk); #1;
            edge_cnt++;
        end
        chk({tag, "_latency"}, 32'(edge_cnt), 32'(LAT));
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk({tag, "_out"}, out, e.res);
        chk({tag, "_flags"}, {28'd0, carryout, overflow, zero, negative},
            {28'd0, e.co, e.ov, e.z, e.n});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, out, e.res);
    endtask

    task automatic run_op(string tag, logic [31:0] a, logic [31:0] b, logic [2:0] c);
        issue(a, b, c);
        wait_done(tag);
    endtask

    int pulses;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", {24'd0, busy, done, carryout, overflow, zero, negative, 2'b00},
            {24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
        chk("reset_out", out, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_5_7",    32'd5,          32'd7,          3'd2);
        run_op("sub_min_1",  32'h8000_0000, 32'd1,          3'd3);
        run_op("add_wrap",   32'hFFFF_FFFF, 32'd1,          3'd2);
        run_op("nor_0_0",    32'd0,          32'd0,          3'd6);
        run_op("xor",        32'hF0F0_F0F0, 32'hFFFF_0000, 3'd7);
        run_op("and",        32'hDEAD_BEEF, 32'h0F0F_F0F0, 3'd4);
        run_op("or",         32'h1234_0000, 32'h0000_5678, 3'd5);
        run_op("sub_neg",    32'd5,          32'd7,          3'd3);
        run_op("add_ovf",    32'h7FFF_FFFF, 32'd1,          3'd2);
        run_op("op0_add",    32'd100,        32'd23,         3'd0);
        run_op("op1_sub",    32'd100,        32'd23,         3'd1);

        // start during RUN must be ignored
        issue(32'd1000, 32'd234, 3'd2);
        repeat (9) begin @(posedge clk); #1; edge_cnt++; end
        A = 32'hAAAA_AAAA; B = 32'h5555_5555; control = 3'd4; start = 1'b1;
        @(posedge clk); #1; edge_cnt++;
        start = 1'b0;
        wait_done("busy_ignore");
        chk("idle_after_ignore", {31'd0, busy}, 32'd0);
        run_op("after_ignore", 32'h0000_FFFF, 32'h0000_0001, 3'd2);

        // reset mid-RUN aborts with no done pulse
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_vals", {26'd0, busy, done, carryout, overflow, zero, negative},
            {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("abort_out", out, 32'd0);
        reset = 1'b0;
        sb_q.delete();
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op("after_abort", 32'd5, 32'd7, 3'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_alu32.md
Name: serial_alu32

Overview:
Bit-serial 32-bit ALU sequencer that sits directly downstream of the 1-bit ALU slice and drives one slice instance, LSB first, one bit per clock.
- Latches operands and opcode on a start handshake.
- Shifts the operand bits through the slice and feeds the slice carry-out back as the next carry-in.
- Assembles the result word and status flags.
- Serves as a low-area alternative to a 32-slice ripple ALU in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
A  input  WIDTH  operand A; latched when start is accepted
B  input  WIDTH  operand B; latched when start is accepted
control  input  3  opcode: 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when the result is valid
out  output  WIDTH  result; held stable from done until the next accepted start
carryout  output  1  carry out of the MSB for arithmetic ops; 0 for logic ops
overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops
zero  output  1  out == 0
negative  output  1  out[WIDTH-1]

Behaviour:
- Reset values: busy=0, done=0, out=0, carryout=0, overflow=0, zero=1, negative=0. State returns to IDLE.
- Reset asserted mid-operation aborts the operation. The next cycle shows reset values; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch A, B, control; bit counter=0.
  - Carry register = control[0] & ~control[2], so SUB (and undefined op 1) starts with carry 1.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: each edge processes bit i=counter:
  - Slice inputs: A_lat[i], B_lat[i], carry register, latched control.
  - Slice out is shifted into result bit i; slice carryout is stored into the carry register.
  - The carry-in of bit WIDTH-1 is saved for overflow.
  - counter increments; at counter==WIDTH-1 the next state is DONE.
- Exactly WIDTH RUN edges occur (k+1 .. k+WIDTH). done=1 in the cycle after edge k+WIDTH, i.e. latency WIDTH+1 cycles from start.
- DONE: done=1 for exactly one cycle, then IDLE. Flags update when entering DONE.
  - overflow = cin_msb ^ cout_msb, gated by ~control[2].
  - carryout = cout_msb & ~control[2].
- start while busy (RUN or DONE) is ignored and never queued. Input changes after acceptance have no effect.
- Opcodes 0 and 1 decode as in the slice: 0 behaves as ADD, 1 as SUB. No error is flagged.
- Logic ops: the carry chain still runs internally; carryout and overflow are forced to 0.

Optional Feature:
SERIAL_ALU_DUAL_SLICE_EN
- Defined:
  - Two slices are chained per cycle; bits 2j and 2j+1 are processed on RUN edge j.
  - RUN lasts WIDTH/2 edges; latency is WIDTH/2+1 cycles.
  - WIDTH must be even; an elaboration error is raised otherwise.
- Undefined: single slice, WIDTH RUN edges, as above.
- Results and flags are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR opcode constants.
  - State encoding constants for IDLE/RUN/DONE.
- One natural sub-module: serial_alu_slice, a combinational 1-bit add/sub/logic slice with the same decode as the existing slice. It is instantiated once, or twice under SERIAL_ALU_DUAL_SLICE_EN.
- FSM, counter, shift registers and flag logic live in serial_alu32.

Test Plan:
- ADD A=5, B=7, start one cycle -> done exactly 33 cycles after the start edge; out=12, carryout=0, overflow=0, zero=0.
- SUB A=0x80000000, B=1 -> out=0x7FFFFFFF, carryout=1, overflow=1, negative=0.
- ADD A=0xFFFFFFFF, B=1 -> out=0, zero=1, carryout=1, overflow=0.
- NOR A=0, B=0 -> out=0xFFFFFFFF, negative=1, carryout=0, overflow=0; XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> 0x0F0FF0F0.
- start re-asserted with new operands during RUN (cycle 10) -> ignored; first result unchanged; a new start in IDLE is then accepted.
- reset at RUN cycle 10 -> next cycle busy=0, done=0, out=0, zero=1; no done pulse follows; with the macro defined, repeat the ADD test and expect done 17 cycles after start.
